// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU select codes and datapath mux selects.
package mips_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADR  = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_RTYPE_EX = 4'd6;
    localparam logic [3:0] ST_RTYPE_WB = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_ADDI_EX  = 4'd9;
    localparam logic [3:0] ST_ADDI_WB  = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_HALT     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOP_NONE parks the select at 0000 in states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_known_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU select decoder: maps the controller's operation class, or the R-type
// funct field, onto the 4-bit ALU select code.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  alu_op_t    alu_op,
    output logic [3:0] alu_select,
    output logic       bad_funct
);

    logic [3:0] funct_sel;

    // bad_funct reflects funct alone so DECODE can flag it before RTYPE_EX.
    always_comb begin
        funct_sel = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  funct_sel = ALU_ADD;
            FN_SUB:  funct_sel = ALU_SUB;
            FN_AND:  funct_sel = ALU_AND;
            FN_OR:   funct_sel = ALU_OR;
            FN_SLT:  funct_sel = ALU_SLT;
            FN_NOR:  funct_sel = ALU_NOR;
            default: bad_funct = 1'b1;
        endcase
    end

    always_comb begin
        alu_select = ALU_AND;
        case (alu_op)
            ALUOP_ADD:   alu_select = ALU_ADD;
            ALUOP_SUB:   alu_select = ALU_SUB;
            ALUOP_FUNCT: alu_select = funct_sel;
            default:     alu_select = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multi_control.sv
// Multicycle MIPS main control FSM. Moore outputs from the state register,
// forced to zero while reset is asserted; branch pc_en is qualified by zero.
//
// state    | meaning
// FETCH    | read instruction, load IR, PC <= PC + 4
// DECODE   | read registers, precompute branch target
// MEM_ADR  | base + offset for LW/SW
// MEM_RD   | load data memory read
// MEM_WB   | load data to rt
// MEM_WR   | store data memory write
// RTYPE_EX | ALU op selected by funct
// RTYPE_WB | ALU result to rd
// BRANCH   | compare A/B, conditional PC update
// ADDI_EX  | A + immediate
// ADDI_WB  | ALU result to rt
// JUMP     | PC <= jump target
// HALT     | parked after an illegal opcode, until reset
module mips_multi_control
    import mips_pkg::*;
#(
    parameter logic [3:0] RESET_STATE      = ST_FETCH,
    parameter bit         ILLEGAL_TO_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_select,
    output logic       illegal
);

    logic [3:0] state_q, state_d;
    ctrl_t      ctrl;
    alu_op_t    alu_op;
    logic       bad_funct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = ST_MEM_ADR;
                    OP_RTYPE:       state_d = ST_RTYPE_EX;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_ADDI:        state_d = ST_ADDI_EX;
                    OP_J:           state_d = ST_JUMP;
                    default:        state_d = ILLEGAL_TO_FETCH ? ST_FETCH : ST_HALT;
                endcase
            end
            ST_MEM_ADR:  state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = ST_MEM_WB;
            ST_RTYPE_EX: state_d = ST_RTYPE_WB;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Gating on rst_n drops every enable the moment reset asserts, not at the next edge.
    always_comb begin
        ctrl   = '0;
        alu_op = ALUOP_NONE;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.pc_en     = 1'b1;
                    alu_op         = ALUOP_ADD;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.illegal   = !is_known_opcode(opcode) ||
                                     ((opcode == OP_RTYPE) && bad_funct);
                    alu_op         = ALUOP_ADD;
                end
                ST_MEM_ADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    alu_op         = ALUOP_ADD;
                end
                ST_MEM_RD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                ST_RTYPE_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    alu_op         = ALUOP_FUNCT;
                end
                ST_RTYPE_WB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.pc_source = PCSRC_ALUOUT;
                    ctrl.pc_en     = (opcode == OP_BNE) ? ~zero : zero;
                    alu_op         = ALUOP_SUB;
                end
                ST_ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    alu_op         = ALUOP_ADD;
                end
                ST_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                ST_JUMP: begin
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.pc_en     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mips_alu_decoder u_alu_dec (
        .funct      (funct),
        .alu_op     (alu_op),
        .alu_select (alu_select),
        .bad_funct  (bad_funct)
    );

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_source  = ctrl.pc_source;
    assign illegal    = ctrl.illegal;

endmodule
